hwpe_stream_strided_addrgen: RTL and testbench

//  Upstream stage of the HWPE stream source/sink: walks a 3-level strided pattern (word/line/feature).

---
 rtl/hwpe_stream_strided_addrgen.sv | 184 ++++++++++++++++++
 tb/tb_hwpe_stream_strided_addrgen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_strided_addrgen.sv
// hwpe_stream_strided_addrgen
// Upstream address generator for an HWPE stream source/sink. Walks a
// three-level strided pattern (word / line / feature) and emits one byte
// address per valid/ready handshake. It reports IDLE/WORKING/DONE progress
// and per-handshake update flags to the controller.

module hwpe_stream_strided_addrgen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned STEP       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] trans_size_i,
  input  logic [CNT_WIDTH-1:0]  line_length_i,
  input  logic [CNT_WIDTH-1:0]  line_stride_i,
  input  logic [CNT_WIDTH-1:0]  feat_length_i,
  input  logic [CNT_WIDTH-1:0]  feat_stride_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic                  ready_start_o,
  output logic                  done_o,
  output logic                  word_update_o,
  output logic                  line_update_o,
  output logic                  feat_update_o,
  output logic                  in_progress_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WORKING = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e                state_q,      state_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [ADDR_WIDTH-1:0] line_base_q,  line_base_d;
  logic [ADDR_WIDTH-1:0] feat_base_q,  feat_base_d;
  logic [ADDR_WIDTH-1:0] trans_cnt_q,  trans_cnt_d;
  logic [ADDR_WIDTH-1:0] trans_size_q, trans_size_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q,   word_cnt_d;
  logic [CNT_WIDTH-1:0]  line_cnt_q,   line_cnt_d;
  logic [CNT_WIDTH-1:0]  line_len_q,   line_len_d;
  logic [CNT_WIDTH-1:0]  line_str_q,   line_str_d;
  logic [CNT_WIDTH-1:0]  feat_len_q,   feat_len_d;
  logic [CNT_WIDTH-1:0]  feat_str_q,   feat_str_d;

  logic handshake;
  logic last_word;
  logic last_line;
  logic last_trans;

  // Handshake and end-of-line/feature/transfer decode from the latched configuration
  always_comb begin
    handshake  = (state_q == WORKING) && addr_ready_i;
    last_word  = (word_cnt_q == line_len_q - CNT_WIDTH'(1));
    last_line  = (line_cnt_q == feat_len_q - CNT_WIDTH'(1));
    last_trans = (trans_cnt_q == trans_size_q - ADDR_WIDTH'(1));
  end

  // Next-state logic: FSM transitions and the strided address walk
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    line_base_d  = line_base_q;
    feat_base_d  = feat_base_q;
    trans_cnt_d  = trans_cnt_q;
    trans_size_d = trans_size_q;
    word_cnt_d   = word_cnt_q;
    line_cnt_d   = line_cnt_q;
    line_len_d   = line_len_q;
    line_str_d   = line_str_q;
    feat_len_d   = feat_len_q;
    feat_str_d   = feat_str_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (trans_size_i == '0) begin
            // Empty transfer: report completion without emitting anything.
            state_d = DONE;
          end else begin
            state_d      = WORKING;
            addr_d       = base_addr_i;
            line_base_d  = base_addr_i;
            feat_base_d  = base_addr_i;
            trans_cnt_d  = '0;
            word_cnt_d   = '0;
            line_cnt_d   = '0;
            trans_size_d = trans_size_i;
            // Zero lengths behave as one so the last-index compares stay meaningful.
            line_len_d   = (line_length_i == '0) ? CNT_WIDTH'(1) : line_length_i;
            feat_len_d   = (feat_length_i == '0) ? CNT_WIDTH'(1) : feat_length_i;
            line_str_d   = line_stride_i;
            feat_str_d   = feat_stride_i;
          end
        end
      end

      WORKING: begin
        if (handshake) begin
          trans_cnt_d = trans_cnt_q + ADDR_WIDTH'(1);
          if (!last_word) begin
            addr_d     = addr_q + ADDR_WIDTH'(STEP);
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
          end else if (!last_line) begin
            line_base_d = line_base_q + ADDR_WIDTH'(line_str_q);
            addr_d      = line_base_q + ADDR_WIDTH'(line_str_q);
            word_cnt_d  = '0;
            line_cnt_d  = line_cnt_q + CNT_WIDTH'(1);
          end else begin
            feat_base_d = feat_base_q + ADDR_WIDTH'(feat_str_q);
            line_base_d = feat_base_q + ADDR_WIDTH'(feat_str_q);
            addr_d      = feat_base_q + ADDR_WIDTH'(feat_str_q);
            word_cnt_d  = '0;
            line_cnt_d  = '0;
          end
          // The transfer length wins over any line/feature position.
          if (last_trans) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset and soft clear
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni || clear_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      line_base_q  <= '0;
      feat_base_q  <= '0;
      trans_cnt_q  <= '0;
      trans_size_q <= '0;
      word_cnt_q   <= '0;
      line_cnt_q   <= '0;
      line_len_q   <= '0;
      line_str_q   <= '0;
      feat_len_q   <= '0;
      feat_str_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      line_base_q  <= line_base_d;
      feat_base_q  <= feat_base_d;
      trans_cnt_q  <= trans_cnt_d;
      trans_size_q <= trans_size_d;
      word_cnt_q   <= word_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_len_q   <= line_len_d;
      line_str_q   <= line_str_d;
      feat_len_q   <= feat_len_d;
      feat_str_q   <= feat_str_d;
    end
  end

  // Status decoded from the registered state; update flags follow the handshake
  always_comb begin
    addr_o        = addr_q;
    addr_valid_o  = (state_q == WORKING);
    ready_start_o = (state_q == IDLE);
    done_o        = (state_q == DONE);
    in_progress_o = (state_q == WORKING);
    word_update_o = handshake;
    line_update_o = handshake && last_word;
    feat_update_o = handshake && last_word && last_line;
  end

endmodule

// File: tb/tb_hwpe_stream_strided_addrgen.sv
// Self-checking bench for hwpe_stream_strided_addrgen: table-driven transfers
// plus hand-written sequences for empty transfers, reset and clear aborts.

module tb_hwpe_stream_strided_addrgen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] trans_size_i;
  logic [15:0] line_length_i;
  logic [15:0] line_stride_i;
  logic [15:0] feat_length_i;
  logic [15:0] feat_stride_i;
  logic [31:0] addr_o;
  logic        addr_valid_o;
  logic        addr_ready_i;
  logic        ready_start_o;
  logic        done_o;
  logic        word_update_o;
  logic        line_update_o;
  logic        feat_update_o;
  logic        in_progress_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  hwpe_stream_strided_addrgen #(
    .ADDR_WIDTH(32),
    .CNT_WIDTH (16),
    .STEP      (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .trans_size_i (trans_size_i),
    .line_length_i(line_length_i),
    .line_stride_i(line_stride_i),
    .feat_length_i(feat_length_i),
    .feat_stride_i(feat_stride_i),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .ready_start_o(ready_start_o),
    .done_o       (done_o),
    .word_update_o(word_update_o),
    .line_update_o(line_update_o),
    .feat_update_o(feat_update_o),
    .in_progress_o(in_progress_o)
  );

  typedef struct {
    logic [31:0] base;
    logic [15:0] ll;
    logic [15:0] ls;
    logic [15:0] fl;
    logic [15:0] fs;
    logic [31:0] trans;
    int          n;
    logic [31:0] exp_addr [8];
    logic [7:0]  line_m;
    logic [7:0]  feat_m;
    bit          rand_ready;
    bit          hold_start;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic load_cfg(input vec_t v);
    base_addr_i   = v.base;
    line_length_i = v.ll;
    line_stride_i = v.ls;
    feat_length_i = v.fl;
    feat_stride_i = v.fs;
    trans_size_i  = v.trans;
  endtask

  // Runs one transfer from IDLE through DONE back to IDLE, comparing every accepted address.
  task automatic run_vec(input vec_t v);
    int          got;
    int          cyc;
    bit          stalled;
    logic [31:0] held;
    @(negedge clk_i);
    load_cfg(v);
    start_i      = 1'b1;
    addr_ready_i = 1'b0;
    @(negedge clk_i);
    if (!v.hold_start) start_i = 1'b0;
    // Scramble the config inputs: the walk must use the latched copies.
    base_addr_i   = 32'hDEAD_BEEF;
    line_length_i = 16'd7;
    line_stride_i = 16'h0ABC;
    feat_length_i = 16'd5;
    feat_stride_i = 16'h1234;
    trans_size_i  = 32'd1;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (got < v.n && cyc < 200) begin
      addr_ready_i = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("valid_in_working", {31'd0, addr_valid_o}, 32'd1);
      if (stalled) check("addr_stable", addr_o, held);
      if (addr_ready_i) begin
        check($sformatf("addr[%0d]", got), addr_o, v.exp_addr[got]);
        check($sformatf("word_upd[%0d]", got), {31'd0, word_update_o}, 32'd1);
        check($sformatf("line_upd[%0d]", got), {31'd0, line_update_o}, {31'd0, v.line_m[got]});
        check($sformatf("feat_upd[%0d]", got), {31'd0, feat_update_o}, {31'd0, v.feat_m[got]});
        got++;
        stalled = 1'b0;
      end else begin
        check("no_upd_on_stall", {31'd0, word_update_o}, 32'd0);
        stalled = 1'b1;
        held    = addr_o;
      end
      cyc++;
      @(negedge clk_i);
    end
    if (got != v.n) check("handshake_budget", got, v.n);
    addr_ready_i = 1'b0;
    start_i      = 1'b0;
    #1;
    check("done_pulse", {31'd0, done_o}, 32'd1);
    check("valid_low_in_done", {31'd0, addr_valid_o}, 32'd0);
    @(negedge clk_i);
    #1;
    check("idle_after_done", {31'd0, ready_start_o}, 32'd1);
    check("done_cleared", {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    // Test 1: two features of two 3-word lines, always ready.
    vecs[0] = '{base: 32'h1000, ll: 16'd3, ls: 16'h100, fl: 16'd2, fs: 16'h1000, trans: 32'd8, n: 8,
                exp_addr: '{32'h1000, 32'h1004, 32'h1008, 32'h1100, 32'h1104, 32'h1108, 32'h2000, 32'h2004},
                line_m: 8'b0010_0100, feat_m: 8'b0010_0000, rand_ready: 1'b0, hold_start: 1'b0};
    // Test 2: same walk under random backpressure.
    vecs[1] = vecs[0];
    vecs[1].rand_ready = 1'b1;
    // Test 4: address wrap past 2^32.
    vecs[2] = '{base: 32'hFFFF_FFF8, ll: 16'd4, ls: 16'h0, fl: 16'd1, fs: 16'h0, trans: 32'd4, n: 4,
                exp_addr: '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0},
                line_m: 8'b0000_1000, feat_m: 8'b0000_1000, rand_ready: 1'b0, hold_start: 1'b0};
    // Test 6: zero lengths act as one; every handshake ends a line and a feature.
    vecs[3] = '{base: 32'h0, ll: 16'd0, ls: 16'h20, fl: 16'd0, fs: 16'h40, trans: 32'd3, n: 3,
                exp_addr: '{32'h0, 32'h40, 32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                line_m: 8'b0000_0111, feat_m: 8'b0000_0111, rand_ready: 1'b0, hold_start: 1'b1};

    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    start_i      = 1'b0;
    addr_ready_i = 1'b0;
    load_cfg(vecs[0]);
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ready_start", {31'd0, ready_start_o}, 32'd1);
    check("rst_valid", {31'd0, addr_valid_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_in_progress", {31'd0, in_progress_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
    end

    // Test 3: empty transfer goes straight to DONE, then IDLE.
    @(negedge clk_i);
    load_cfg(vecs[0]);
    trans_size_i = 32'd0;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("empty_done", {31'd0, done_o}, 32'd1);
    check("empty_no_valid", {31'd0, addr_valid_o}, 32'd0);
    check("empty_not_idle", {31'd0, ready_start_o}, 32'd0);
    @(negedge clk_i);
    #1;
    check("empty_back_idle", {31'd0, ready_start_o}, 32'd1);
    check("empty_done_clr", {31'd0, done_o}, 32'd0);
    check("empty_still_no_valid", {31'd0, addr_valid_o}, 32'd0);

    // Test 5: reset after the third handshake aborts, then a fresh start restarts from base.
    @(negedge clk_i);
    load_cfg(vecs[0]);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i      = 1'b0;
    addr_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    check("pre_rst_addr", addr_o, 32'h1100);
    rst_ni       = 1'b0;
    addr_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("abort_valid", {31'd0, addr_valid_o}, 32'd0);
    check("abort_idle", {31'd0, ready_start_o}, 32'd1);
    check("abort_addr", addr_o, 32'd0);
    check("abort_no_done", {31'd0, done_o}, 32'd0);
    run_vec(vecs[0]);

    // Soft clear mid-transfer behaves like reset.
    @(negedge clk_i);
    load_cfg(vecs[0]);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i      = 1'b0;
    addr_ready_i = 1'b1;
    @(negedge clk_i);
    clear_i      = 1'b1;
    addr_ready_i = 1'b0;
    @(negedge clk_i);
    clear_i = 1'b0;
    #1;
    check("clear_valid", {31'd0, addr_valid_o}, 32'd0);
    check("clear_idle", {31'd0, ready_start_o}, 32'd1);
    check("clear_addr", addr_o, 32'd0);
    repeat (2) @(negedge clk_i);
    #1;
    check("clear_stays_idle", {31'd0, in_progress_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
